// File: rtl/branch_resolve_unit_if.sv
// Issue-side bus of the branch resolve unit: operands in, resolved next-PC out, plus the BHT lookup.
// master = issue/fetch side driving operands, slave = branch_resolve_unit.
interface branch_resolve_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            in_valid;
    logic [3:0]      br;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_val;
    logic            pred_taken;
    logic            stall;
    logic            flush;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_pred;
    logic            out_valid;
    logic            success;
    logic            redirect;
    logic            misalign;
    logic [XLEN-1:0] new_address;

    modport master (
        output in_valid, br, rs1, rs2, imm, pc_val, pred_taken, stall, flush, fetch_pc,
        input  fetch_pred, out_valid, success, redirect, misalign, new_address
    );

    modport slave (
        input  in_valid, br, rs1, rs2, imm, pc_val, pred_taken, stall, flush, fetch_pc,
        output fetch_pred, out_valid, success, redirect, misalign, new_address
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves branches/jumps one cycle after capture; stall holds all state, flush kills the in-flight result.
// Define BRANCH_PREDICT_EN for the 2-bit BHT and redirect-on-mispredict; otherwise redirect mirrors success.
module branch_resolve_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter int              BHT_DEPTH = 64,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h00400004
) (
    input logic                  clk,
    input logic                  reset_n,
    branch_resolve_unit_if.slave bus
);
    localparam logic [3:0] BR_BEQ  = 4'd1;
    localparam logic [3:0] BR_BNE  = 4'd2;
    localparam logic [3:0] BR_BLT  = 4'd3;
    localparam logic [3:0] BR_BGE  = 4'd4;
    localparam logic [3:0] BR_BLTU = 4'd5;
    localparam logic [3:0] BR_BGEU = 4'd6;
    localparam logic [3:0] BR_JAL  = 4'd7;
    localparam logic [3:0] BR_JALR = 4'd8;

    logic            out_valid_q, out_valid_d;
    logic            success_q, success_d;
    logic            redirect_q, redirect_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] new_address_q, new_address_d;

    logic            is_cond, is_jump, taken;
    logic            cmp_eq, cmp_lt_s, cmp_lt_u;
    logic [XLEN-1:0] pc_rel, jalr_sum, target, fall_thru;
    logic            code_ok, capture, redirect_sel;

    assign cmp_eq   = (bus.rs1 == bus.rs2);
    assign cmp_lt_s = ($signed(bus.rs1) < $signed(bus.rs2));
    assign cmp_lt_u = (bus.rs1 < bus.rs2);

    always_comb begin
        is_cond = 1'b0;
        is_jump = 1'b0;
        taken   = 1'b0;
        case (bus.br)
            BR_BEQ:  begin is_cond = 1'b1; taken = cmp_eq;    end
            BR_BNE:  begin is_cond = 1'b1; taken = !cmp_eq;   end
            BR_BLT:  begin is_cond = 1'b1; taken = cmp_lt_s;  end
            BR_BGE:  begin is_cond = 1'b1; taken = !cmp_lt_s; end
            BR_BLTU: begin is_cond = 1'b1; taken = cmp_lt_u;  end
            BR_BGEU: begin is_cond = 1'b1; taken = !cmp_lt_u; end
            BR_JAL, BR_JALR: begin is_jump = 1'b1; taken = 1'b1; end
            default: ;
        endcase
    end

    assign pc_rel    = bus.pc_val + bus.imm;
    assign jalr_sum  = bus.rs1 + bus.imm;
    assign target    = (bus.br == BR_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_rel;
    assign fall_thru = bus.pc_val + XLEN'(4);

    // code_ok ignores stall/flush; capture is the actual state-changing event
    assign code_ok = bus.in_valid && (is_cond || is_jump);
    assign capture = code_ok && !bus.stall && !bus.flush;

`ifdef BRANCH_PREDICT_EN
    localparam int IDXW = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

    logic [1:0]      bht_q [BHT_DEPTH];
    logic [1:0]      bht_cur, bht_d;
    logic [IDXW-1:0] upd_idx, fetch_idx;
    logic            bht_we;

    assign upd_idx   = bus.pc_val[IDXW+1:2];
    assign fetch_idx = bus.fetch_pc[IDXW+1:2];
    assign bht_cur   = bht_q[upd_idx];
    assign bht_we    = capture && is_cond;

    always_comb begin
        bht_d = bht_cur;
        if (taken) begin
            if (bht_cur != 2'b11) bht_d = bht_cur + 2'b01;
        end else begin
            if (bht_cur != 2'b00) bht_d = bht_cur - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
        end else if (bht_we) begin
            bht_q[upd_idx] <= bht_d;
        end
    end

    // lookup reads the array before this edge's write lands
    assign bus.fetch_pred = bht_q[fetch_idx][1];
    assign redirect_sel   = (taken != bus.pred_taken);
`else
    logic unused_pred;
    assign unused_pred    = ^{bus.pred_taken, bus.fetch_pc};
    assign bus.fetch_pred = 1'b0;
    assign redirect_sel   = taken;
`endif

    always_comb begin
        out_valid_d   = out_valid_q;
        success_d     = success_q;
        redirect_d    = redirect_q;
        misalign_d    = misalign_q;
        new_address_d = new_address_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (!bus.stall) begin
            out_valid_d = code_ok;
            if (code_ok) begin
                success_d     = taken;
                redirect_d    = redirect_sel;
                misalign_d    = taken && target[1];
                new_address_d = taken ? target : fall_thru;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q   <= 1'b0;
            success_q     <= 1'b0;
            redirect_q    <= 1'b0;
            misalign_q    <= 1'b0;
            new_address_q <= RESET_PC;
        end else begin
            out_valid_q   <= out_valid_d;
            success_q     <= success_d;
            redirect_q    <= redirect_d;
            misalign_q    <= misalign_d;
            new_address_q <= new_address_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.success     = success_q;
    assign bus.redirect    = redirect_q;
    assign bus.misalign    = misalign_q;
    assign bus.new_address = new_address_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed cases plus random traffic against a behavioural model.
module tb_branch_resolve_unit;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 64;
    localparam logic [31:0] RST_PC   = 32'h00400004;

    typedef struct packed {
        logic        ov;
        logic        succ;
        logic        redir;
        logic        mis;
        logic [31:0] na;
    } out_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(XLEN)) bus ();

    branch_resolve_unit #(
        .XLEN      (XLEN),
        .BHT_DEPTH (DEPTH),
        .RESET_PC  (RST_PC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    out_t exp_q[$];
    logic fp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    out_t m;
    int   bht[DEPTH];

    function automatic logic model_fetch_pred(input logic [31:0] fpc);
`ifdef BRANCH_PREDICT_EN
        return bht[int'((fpc >> 2) % DEPTH)] >= 2;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m = '{ov: 1'b0, succ: 1'b0, redir: 1'b0, mis: 1'b0, na: RST_PC};
        for (int i = 0; i < DEPTH; i++) bht[i] = 1;
    endtask

    task automatic model_step(input logic rst_n, iv, input logic [3:0] b,
                              input logic [31:0] a, c, im, pc, input logic pt, st, fl);
        logic        tk;
        logic [31:0] tgt;
        int          sa, sb, idx;
        if (!rst_n) begin model_reset(); return; end
        if (fl) begin m.ov = 1'b0; return; end
        if (st) return;
        if (!iv || b < 4'd1 || b > 4'd8) begin m.ov = 1'b0; return; end
        sa = a;
        sb = c;
        case (b)
            4'd1:    tk = (a == c);
            4'd2:    tk = (a != c);
            4'd3:    tk = (sa < sb);
            4'd4:    tk = (sa >= sb);
            4'd5:    tk = (a < c);
            4'd6:    tk = (a >= c);
            default: tk = 1'b1;
        endcase
        tgt    = (b == 4'd8) ? ((a + im) & 32'hFFFF_FFFE) : (pc + im);
        m.ov   = 1'b1;
        m.succ = tk;
        m.mis  = tk && tgt[1];
        m.na   = tk ? tgt : pc + 32'd4;
`ifdef BRANCH_PREDICT_EN
        m.redir = (tk != pt);
        if (b <= 4'd6) begin
            idx = int'((pc >> 2) % DEPTH);
            bht[idx] = tk ? ((bht[idx] == 3) ? 3 : bht[idx] + 1) : ((bht[idx] == 0) ? 0 : bht[idx] - 1);
        end
`else
        m.redir = tk;
`endif
    endtask

    task automatic drive(input logic rst_n, iv, input logic [3:0] b,
                         input logic [31:0] a, c, im, pc, input logic pt, st, fl,
                         input logic [31:0] fpc);
        @(negedge clk);
        reset_n        = rst_n;
        bus.in_valid   = iv;
        bus.br         = b;
        bus.rs1        = a;
        bus.rs2        = c;
        bus.imm        = im;
        bus.pc_val     = pc;
        bus.pred_taken = pt;
        bus.stall      = st;
        bus.flush      = fl;
        bus.fetch_pc   = fpc;
        fp_q.push_back(model_fetch_pred(fpc));
        model_step(rst_n, iv, b, a, c, im, pc, pt, st, fl);
        exp_q.push_back(m);
    endtask

    task automatic idle(input logic [31:0] fpc);
        drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, fpc);
    endtask

    task automatic monitor();
        logic e_fp;
        out_t e, got;
        forever begin
            @(negedge clk);
            #2;
            vectors++;
            if (fp_q.size() == 0) begin
                miscompares++;
                $display("FAIL fetch_pred_queue: no expectation queued at %0t", $time);
            end else begin
                e_fp = fp_q.pop_front();
                if (bus.fetch_pred !== e_fp) begin
                    miscompares++;
                    $display("FAIL fetch_pred at %0t: got %b expected %b (fetch_pc %h)",
                             $time, bus.fetch_pred, e_fp, bus.fetch_pc);
                end
            end
            @(posedge clk);
            #1;
            vectors++;
            got = '{ov: bus.out_valid, succ: bus.success, redir: bus.redirect,
                    mis: bus.misalign, na: bus.new_address};
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL outputs_queue: no expectation queued at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL outputs at %0t: got v=%b s=%b r=%b m=%b a=%h expected v=%b s=%b r=%b m=%b a=%h",
                             $time, got.ov, got.succ, got.redir, got.mis, got.na,
                             e.ov, e.succ, e.redir, e.mis, e.na);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r1, r2, im, pc, fpc;
        reset_n        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.br         = 4'd0;
        bus.rs1        = '0;
        bus.rs2        = '0;
        bus.imm        = '0;
        bus.pc_val     = '0;
        bus.pred_taken = 1'b0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.fetch_pc   = '0;
        model_reset();
        repeat (2) @(posedge clk);

        fork
            monitor();
        join_none

        // reset dominates a valid capture with stall/flush noise
        drive(1'b0, 1'b1, 4'd1, 32'd5, 32'd5, 32'd8, 32'h0040_0040, 1'b1, 1'b1, 1'b0, 32'h0040_0040);
        drive(1'b0, 1'b1, 4'd7, 32'd5, 32'd5, 32'd8, 32'h0040_0040, 1'b1, 1'b0, 1'b1, 32'h0040_0010);

        // signed vs unsigned compare of -1 against 1
        drive(1'b1, 1'b1, 4'd5, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h0040_0020, 1'b0, 1'b0, 1'b0, 32'h0040_0020);
        drive(1'b1, 1'b1, 4'd3, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h0040_0020, 1'b0, 1'b0, 1'b0, 32'h0040_0020);

        // JALR bit-0 clear and misalign
        drive(1'b1, 1'b1, 4'd8, 32'h0040_0101, 32'd0, 32'd4, 32'h0040_0030, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 4'd8, 32'h0040_0101, 32'd0, 32'd6, 32'h0040_0030, 1'b1, 1'b0, 1'b0, 32'h0);

        // counter saturation and pre-update lookup at the same index
        repeat (4) drive(1'b1, 1'b1, 4'd1, 32'd7, 32'd7, 32'h20, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 32'h0040_0010);
        drive(1'b1, 1'b1, 4'd1, 32'd7, 32'd8, 32'h20, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 32'h0040_0010);
        idle(32'h0040_0010);

        // mispredicted not-taken BNE whose fall-through wraps to zero
        drive(1'b1, 1'b1, 4'd2, 32'd3, 32'd3, 32'h10, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0);

        // capture, three stalled cycles, then flush over stall with a valid input
        drive(1'b1, 1'b1, 4'd4, 32'd9, 32'd2, 32'h80, 32'h0040_0010, 1'b0, 1'b0, 1'b0, 32'h0040_0010);
        repeat (3) drive(1'b1, 1'b1, 4'd2, 32'd1, 32'd2, 32'h8, 32'h0040_0010, 1'b0, 1'b1, 1'b0, 32'h0040_0010);
        drive(1'b1, 1'b1, 4'd2, 32'd1, 32'd2, 32'h8, 32'h0040_0010, 1'b0, 1'b1, 1'b1, 32'h0040_0010);
        idle(32'h0040_0010);

        // reset while a result is held, then scan every predictor index
        drive(1'b1, 1'b1, 4'd7, 32'd0, 32'd0, 32'h100, 32'h0040_0050, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 4'd7, 32'd0, 32'd0, 32'h100, 32'h0040_0050, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < DEPTH; i++) idle(32'(i * 4));

        // invalid codes never capture
        for (int c = 9; c < 16; c++)
            drive(1'b1, 1'b1, 4'(c), 32'd1, 32'd1, 32'd4, 32'h0040_0010, 1'b0, 1'b0, 1'b0, 32'h0040_0010);

        for (int n = 0; n < 600; n++) begin
            r1  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 + $urandom_range(0, 3) - 2 : $urandom;
            r2  = ($urandom_range(0, 2) == 0) ? r1 : (($urandom_range(0, 1) == 0) ? r1 + $urandom_range(0, 4) - 2 : $urandom);
            im  = 32'($signed($urandom_range(0, 255)) - 128);
            pc  = ($urandom_range(0, 3) != 0) ? 32'h0040_0000 + 32'($urandom_range(0, 15) * 4) : $urandom;
            fpc = ($urandom_range(0, 3) != 0) ? 32'h0040_0000 + 32'($urandom_range(0, 15) * 4) : $urandom;
            drive($urandom_range(0, 39) != 0, $urandom_range(0, 4) != 0, 4'($urandom_range(0, 15)),
                  r1, r2, im, pc, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0, fpc);
        end

        @(posedge clk);
        #3;
        vectors++;
        if (exp_q.size() != 0 || fp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d output and %0d lookup expectations left, required 0",
                     exp_q.size(), fp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand, PC and address width.
REQ-002 SHALL have parameter BHT_DEPTH, default 64: predictor entries; power of 2, at least 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h00400004: new_address value while in reset.
REQ-004 SHALL have port clk  in  1: rising-edge clock.
REQ-005 SHALL have port reset_n  in  1: synchronous, active-low reset.
REQ-006 SHALL have port in_valid  in  1: br/operands valid this cycle.
REQ-007 SHALL have port br  in  4: branch code; 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JAL, 8 JALR, 9-15 none.
REQ-008 SHALL have ports rs1, rs2, imm, pc_val  in  XLEN each: operands, sign-extended offset, branch PC.
REQ-009 SHALL have port pred_taken  in  1: direction fetch predicted for this branch.
REQ-010 SHALL have ports stall, flush  in  1 each: hold, and kill the in-flight result.
REQ-011 SHALL have port fetch_pc  in  XLEN and port fetch_pred  out  1: predictor lookup.
REQ-012 SHALL have ports out_valid, success, redirect, misalign  out  1 each, and port new_address  out  XLEN.

Function
REQ-013 Capture SHALL occur on a clk edge with reset_n=1, flush=0, stall=0, in_valid=1 and br in 1..8; latency one cycle, all outputs registered except fetch_pred.
REQ-014 On a capture edge, out_valid SHALL become 1; on any other edge with stall=0, out_valid SHALL become 0.
REQ-015 While stall=1 and flush=0, all registered outputs and predictor state SHALL hold.
REQ-016 flush=1 SHALL take priority over stall and capture: out_valid 0 next edge, and no predictor update.
REQ-017 BEQ/BNE SHALL compare rs1==rs2; BLT/BGE SHALL use signed XLEN compare; BLTU/BGEU SHALL use unsigned XLEN compare. No subtract-sign shortcut.
REQ-018 JAL SHALL always be taken, target pc_val+imm; JALR SHALL always be taken, target (rs1+imm) with bit 0 cleared; conditional target pc_val+imm; all sums modulo 2^XLEN.
REQ-019 success SHALL register the taken decision; misalign SHALL register taken AND target[1]!=0.
REQ-020 new_address SHALL register target when taken, else pc_val+4 (wraps modulo 2^XLEN).
REQ-021 Predictor: BHT_DEPTH 2-bit saturating counters indexed by address bits [log2(BHT_DEPTH)+1:2]; fetch_pred = MSB of the counter at fetch_pc's index, combinational.
REQ-022 On a capture edge with br 1..6, the counter at pc_val's index SHALL increment if taken, else decrement, saturating at 3 and 0; JAL/JALR SHALL not update.
REQ-023 Same-index lookup and update in one cycle: fetch_pred SHALL return the pre-update value.
REQ-024 Codes 0 and 9-15 SHALL not capture and SHALL not update; out_valid SHALL become 0 if stall=0.

Reset
REQ-025 On an edge with reset_n=0 the block SHALL set out_valid=0, success=0, redirect=0, misalign=0, new_address=RESET_PC, and all counters to 2'b01, regardless of stall/flush/in_valid.
REQ-026 Reset mid-operation SHALL discard any held result; the first capture is possible on the first edge with reset_n=1.

Configuration
REQ-027 With BRANCH_PREDICT_EN defined: redirect SHALL register (success != pred_taken) on capture, and new_address SHALL be the correct next PC.
REQ-028 With BRANCH_PREDICT_EN defined, a flow with correct prediction SHALL get redirect=0.
REQ-029 Without BRANCH_PREDICT_EN: no counter storage; fetch_pred SHALL be tied 0; pred_taken ignored; redirect SHALL register success.

Verification
REQ-030 BLTU and BLT: rs1=32'hFFFFFFFF, rs2=1 -> BLTU success=0; BLT success=1, new_address=pc_val+imm one cycle later.
REQ-031 JALR: rs1=32'h00400101, imm=4 -> new_address=32'h00400104, success=1, misalign=0; imm=6 -> misalign=1.
REQ-032 Predictor: four taken BEQ at pc 32'h00400010 -> counter saturates at 3, fetch_pred=1; then not-taken -> counter 2, fetch_pred stays 1.
REQ-033 With BRANCH_PREDICT_EN, pred_taken=1 and BNE not taken at pc 32'hFFFFFFFC -> redirect=1, new_address=0 (wrap).
REQ-034 Stall held 3 cycles after capture -> outputs and counters unchanged; flush with stall=1 and in_valid=1 -> out_valid=0 and no counter change.
REQ-035 reset_n=0 asserted while out_valid=1 -> next edge: out_valid=0, new_address=32'h00400004, fetch_pred=0 at all indices.
